wb_cmd_master: RTL and testbench

- Byte-stream-controlled Wishbone classic bus master; the initiator end of the classic bus that the crossbar exposes to peripherals.
- Parses simple read/write command packets from a byte source (e.g. the USB serial RX path).
- Issues single Wishbone classic transactions on a crossbar master port and returns status/data bytes on a byte sink.
- Debug/bring-up path to the boot ROM, SRAM, LED PWM and serial peripherals, independent of the CPU.

---
 rtl/wb_cmd_pkg.sv | 18 +
 rtl/wb_cmd_master.sv | 199 +++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_pkg.sv
// Shared opcodes, status bytes and FSM state encoding for the byte-stream
// controlled Wishbone command master.
package wb_cmd_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] RSP_OK    = 8'h00;
    localparam logic [7:0] RSP_ERR   = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        BUS,
        RESP
    } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic master driven by read/write command packets on a byte
// stream; returns a status byte (plus read data) on a byte sink.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_reset_i,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            wb_we_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    output logic            busy
);

    localparam int TW = $clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [23:0]     sr_q, sr_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            rsp_err_q, rsp_err_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic rx_fire, tx_fire, bus_done, bus_tmo, rsp_last;

    assign rx_ready = !wb_reset_i && (state_q inside {IDLE, ADDR, WDATA});
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid_q && tx_ready;
    assign bus_done = wb_ack_i || wb_err_i;
    assign bus_tmo  = (tmo_q == TW'(TIMEOUT - 1));
    // Errors and write acks are a single status byte; read OK adds four data bytes.
    assign rsp_last = rsp_err_q || we_q || (cnt_q == 3'd4);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // and a latch cannot be inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (rx_fire && (rx_data == CMD_WRITE || rx_data == CMD_READ)) state_d = ADDR;
            ADDR:  if (rx_fire && cnt_q == 3'd3) state_d = we_q ? WDATA : BUS;
            WDATA: if (rx_fire && cnt_q == 3'd3) state_d = BUS;
            BUS:   if (bus_done || bus_tmo) state_d = RESP;
            RESP:  if (tx_fire && rsp_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        sr_d       = sr_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdat_d     = rdat_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        rsp_err_d  = rsp_err_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (rx_fire && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    we_d  = (rx_data == CMD_WRITE);
                    cnt_d = 3'd0;
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    sr_d  = {rx_data, sr_q[23:8]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        adr_d = AW'({rx_data, sr_q});
                        cnt_d = 3'd0;
                        if (!we_q) begin
                            cyc_d = 1'b1;
                            tmo_d = '0;
                        end
                    end
                end
            end
            WDATA: begin
                if (rx_fire) begin
                    dat_d = {rx_data, dat_q[DW-1:8]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        cnt_d = 3'd0;
                        cyc_d = 1'b1;
                        tmo_d = '0;
                    end
                end
            end
            BUS: begin
                if (bus_done) begin
                    // err wins when ack and err arrive together.
                    cyc_d      = 1'b0;
                    rdat_d     = wb_dat_i;
                    rsp_err_d  = wb_err_i;
                    tx_valid_d = 1'b1;
                    tx_data_d  = wb_err_i ? RSP_ERR : RSP_OK;
                    cnt_d      = 3'd0;
                end else if (bus_tmo) begin
                    cyc_d      = 1'b0;
                    rsp_err_d  = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RSP_ERR;
                    cnt_d      = 3'd0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                if (tx_fire) begin
                    if (rsp_last) begin
                        tx_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        unique case (cnt_q[1:0])
                            2'd0: tx_data_d = rdat_q[7:0];
                            2'd1: tx_data_d = rdat_q[15:8];
                            2'd2: tx_data_d = rdat_q[23:16];
                            2'd3: tx_data_d = rdat_q[31:24];
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            cnt_q      <= '0;
            tmo_q      <= '0;
            sr_q       <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdat_q     <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            rsp_err_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            sr_q       <= sr_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdat_q     <= rdat_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            rsp_err_q  <= rsp_err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = '1;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench: packets are issued with their expected bus cycle and
// response bytes queued; a slave/bus monitor and a tx monitor check them.
module tb_wb_cmd_master;

    localparam int AW      = 30;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    localparam int K_ACK   = 0;
    localparam int K_ERR   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_NONE  = 3;
    localparam int K_ABORT = 4;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        int          delay;
        int          kind;
        logic [31:0] rdat;
    } txn_t;

    logic            wb_clk_i   = 1'b0;
    logic            wb_reset_i = 1'b1;
    logic [7:0]      rx_data    = 8'h00;
    logic            rx_valid   = 1'b0;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready   = 1'b1;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i   = '0;
    logic            wb_we_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_ack_i   = 1'b0;
    logic            wb_err_i   = 1'b0;
    logic            busy;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_reset_i(wb_reset_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .busy      (busy)
    );

    initial forever #5 wb_clk_i = ~wb_clk_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          tx_mode  = 0;
    txn_t        bus_q[$];
    logic [7:0]  exp_tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic txn_t mk(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                                input int delay, input int kind, input logic [31:0] rdat);
        txn_t t;
        t.adr = adr; t.we = we; t.dat = dat; t.delay = delay; t.kind = kind; t.rdat = rdat;
        return t;
    endfunction

    // Offer one byte; returns once the DUT has taken it (bounded).
    task automatic put_byte(input logic [7:0] b);
        logic acc;
        repeat ($urandom_range(0, 1)) begin
            rx_valid = 1'b0;
            @(posedge wb_clk_i); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = 1'b0;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge wb_clk_i);
            acc = rx_ready;
            @(posedge wb_clk_i); #1;
        end
        rx_valid = 1'b0;
        check("rx_accept", acc, 1'b1);
    endtask

    // Reference model: packet bytes, expected bus cycle and expected response.
    task automatic issue(input txn_t t);
        logic [7:0] b[$];
        b.push_back(t.we ? 8'h01 : 8'h02);
        for (int i = 0; i < 4; i++) b.push_back(t.adr[8*i +: 8]);
        if (t.we) for (int i = 0; i < 4; i++) b.push_back(t.dat[8*i +: 8]);
        bus_q.push_back(t);
        if (t.kind == K_ACK) begin
            exp_tx_q.push_back(8'h00);
            if (!t.we) for (int i = 0; i < 4; i++) exp_tx_q.push_back(t.rdat[8*i +: 8]);
        end else if (t.kind != K_ABORT) begin
            exp_tx_q.push_back(8'hEE);
        end
        foreach (b[i]) put_byte(b[i]);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (bus_q.size() == 0 && exp_tx_q.size() == 0 && !busy && !tx_valid) done = 1'b1;
            else begin @(posedge wb_clk_i); #1; end
        end
        check("drain", done, 1'b1);
    endtask

    // Slave model and bus checker.
    initial begin
        int   bus_n;
        txn_t cur;
        bus_n = 0;
        cur   = mk(0, 0, 0, 0, K_NONE, 0);
        forever begin
            @(posedge wb_clk_i); #1;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = $urandom;
            if (wb_reset_i) begin
                bus_n = 0;
                continue;
            end
            if (wb_cyc_o) begin
                if (bus_n == 0) begin
                    check("bus_expected", 32'(bus_q.size() > 0), 1);
                    if (bus_q.size() > 0) cur = bus_q.pop_front();
                    else cur = mk(0, 0, 0, 0, K_NONE, 0);
                    check("bus_adr", wb_adr_o, cur.adr[AW-1:0]);
                    check("bus_we", wb_we_o, cur.we);
                    if (cur.we) check("bus_wdat", wb_dat_o, cur.dat);
                    check("bus_sel", wb_sel_o, 4'hF);
                    check("bus_stb", wb_stb_o, 1'b1);
                end
                bus_n++;
                if (cur.kind != K_NONE && cur.kind != K_ABORT && bus_n == cur.delay + 1) begin
                    wb_ack_i = (cur.kind != K_ERR);
                    wb_err_i = (cur.kind != K_ACK);
                    wb_dat_i = cur.rdat;
                end
            end else if (bus_n != 0) begin
                if (cur.kind != K_ABORT) begin
                    check("cyc_len", bus_n, (cur.kind == K_NONE) ? TIMEOUT : cur.delay + 1);
                    check("stb_low", wb_stb_o, 1'b0);
                    check("adr_hold", wb_adr_o, cur.adr[AW-1:0]);
                    check("we_hold", wb_we_o, cur.we);
                end
                bus_n = 0;
            end
        end
    end

    // Sink model and response checker.
    initial begin
        logic       stall, tog;
        logic [7:0] held;
        stall = 1'b0; tog = 1'b1; held = 8'h00;
        forever begin
            @(posedge wb_clk_i); #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       begin tx_ready = tog; tog = ~tog; end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge wb_clk_i);
            if (wb_reset_i) begin
                stall = 1'b0;
                continue;
            end
            if (wb_cyc_o) check("rx_ready_bus", rx_ready, 1'b0);
            if (tx_valid) begin
                check("rx_ready_resp", rx_ready, 1'b0);
                if (stall) check("tx_stable", tx_data, held);
                if (tx_ready) begin
                    check("tx_expected", 32'(exp_tx_q.size() > 0), 1);
                    if (exp_tx_q.size() > 0) check("tx_data", tx_data, exp_tx_q.pop_front());
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held  = tx_data;
                end
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        logic seen;
        int   kind;

        rx_valid = 1'b1;
        rx_data  = 8'h01;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rx_ready_in_reset", rx_ready, 1'b0);
        check("rst_cyc", wb_cyc_o, 1'b0);
        check("rst_stb", wb_stb_o, 1'b0);
        check("rst_we", wb_we_o, 1'b0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 1'b0);
        @(posedge wb_clk_i); #1;
        rx_valid   = 1'b0;
        wb_reset_i = 1'b0;

        issue(mk(32'h1000_0004, 1'b1, 32'h1234_5678, 2, K_ACK, 0));
        issue(mk(32'h2000_0000, 1'b0, 0, 0, K_ACK, 32'hDEAD_BEEF));
        wait_idle();

        tx_mode = 1;
        issue(mk(32'h2000_0000, 1'b0, 0, 0, K_ACK, 32'hDEAD_BEEF));
        wait_idle();
        tx_mode = 0;

        issue(mk(32'h0000_0100, 1'b0, 0, 0, K_NONE, 0));
        issue(mk(32'h0000_0200, 1'b1, 32'hCAFE_F00D, 1, K_BOTH, 0));
        issue(mk(32'h0000_0300, 1'b0, 0, 3, K_ERR, 32'h5555_AAAA));
        put_byte(8'h55);
        put_byte(8'hFF);
        issue(mk(32'h0ABC_DEF0, 1'b0, 0, 1, K_ACK, 32'h0BAD_F00D));
        wait_idle();

        // Reset while a bus cycle is open.
        issue(mk(32'h0000_0040, 1'b0, 0, 0, K_ABORT, 0));
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (wb_cyc_o) seen = 1'b1;
            else begin @(posedge wb_clk_i); #1; end
        end
        check("abort_cyc_seen", seen, 1'b1);
        wb_reset_i = 1'b1;
        @(posedge wb_clk_i); #1;
        check("abort_cyc_drop", wb_cyc_o, 1'b0);
        check("abort_no_tx", tx_valid, 1'b0);
        check("abort_idle", busy, 1'b0);
        wb_reset_i = 1'b0;
        repeat (8) @(posedge wb_clk_i);
        #1;
        check("abort_still_quiet", tx_valid, 1'b0);

        // Reset after two address bytes, then a full packet.
        put_byte(8'h01);
        put_byte(8'h34);
        put_byte(8'h12);
        wb_reset_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_reset_i = 1'b0;
        issue(mk(32'h3333_4444, 1'b1, 32'h8765_4321, 0, K_ACK, 0));
        wait_idle();

        for (int n = 0; n < 60; n++) begin
            tx_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) put_byte(8'($urandom_range(3, 255)));
            kind = ($urandom_range(0, 9) < 6) ? K_ACK : $urandom_range(K_ERR, K_NONE);
            issue(mk($urandom, 1'($urandom_range(0, 1)), $urandom,
                     $urandom_range(0, 5), kind, $urandom));
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
